// File: rtl/ofdm_eq_sequencer.sv
// Frames FFT output samples for the channel equalizer: drops samples until a
// frame start, then tags a preamble symbol and N_DATA_SYM data symbols.
module ofdm_eq_sequencer #(
  parameter int DATA_SIZE  = 16,
  parameter int NFFT       = 256,
  parameter int N_DATA_SYM = 14,
  localparam int SC_W      = $clog2(NFFT),
  localparam int SYM_W     = $clog2(N_DATA_SYM) + 1
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [DATA_SIZE-1:0] i_data_i,
  input  logic [DATA_SIZE-1:0] i_data_q,
  input  logic                 i_valid,
  input  logic                 i_frame_start,
  output logic                 o_ready,
  input  logic                 i_eq_wait,
  output logic [DATA_SIZE-1:0] o_eq_data_i,
  output logic [DATA_SIZE-1:0] o_eq_data_q,
  output logic                 o_eq_valid,
  output logic                 o_eq_sync_frame,
  output logic                 o_is_preamble,
  output logic [SC_W-1:0]      o_sc_idx,
  output logic [SYM_W-1:0]     o_sym_idx,
  output logic                 o_frame_done,
  output logic                 o_err_resync,
  output logic [1:0]           o_dbg_state
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2
  } state_t;

  localparam logic [SC_W-1:0]  SC_LAST  = SC_W'(NFFT - 1);
  localparam logic [SYM_W-1:0] SYM_LAST = SYM_W'(N_DATA_SYM - 1);

  state_t           state, state_n;
  logic [SC_W-1:0]  sc_cnt, sc_n;
  logic [SYM_W-1:0] sym_cnt, sym_n;
  logic             xfer, fwd, sync_n, err_n, done_n, pre_n;
  logic [SC_W-1:0]  osc_n;
  logic [SYM_W-1:0] osym_n;

  // Handshake: a sample transfers on a clock edge where i_valid && o_ready;
  // o_ready only drops while the equalizer is busy (or reset is held), and
  // nothing advances on a cycle without a transfer.
  assign o_ready     = !i_eq_wait && !i_reset;
  assign xfer        = i_valid && o_ready;
  assign o_dbg_state = state;

  always_comb begin
    state_n = state;
    sc_n    = sc_cnt;
    sym_n   = sym_cnt;
    fwd     = 1'b0;
    sync_n  = 1'b0;
    err_n   = 1'b0;
    done_n  = 1'b0;
    pre_n   = o_is_preamble;
    osc_n   = o_sc_idx;
    osym_n  = o_sym_idx;
    if (xfer) begin
      if (i_frame_start) begin
        // A frame start always restarts, even over the last sample of a frame.
        fwd     = 1'b1;
        sync_n  = 1'b1;
        err_n   = (state != ST_IDLE);
        pre_n   = 1'b1;
        osc_n   = '0;
        osym_n  = '0;
        state_n = ST_PREAMBLE;
        sc_n    = SC_W'(1);
        sym_n   = '0;
      end else begin
        case (state)
          ST_PREAMBLE: begin
            fwd    = 1'b1;
            pre_n  = 1'b1;
            osc_n  = sc_cnt;
            osym_n = '0;
            if (sc_cnt == SC_LAST) begin
              state_n = ST_DATA;
              sc_n    = '0;
              sym_n   = '0;
            end else begin
              sc_n = sc_cnt + SC_W'(1);
            end
          end
          ST_DATA: begin
            fwd    = 1'b1;
            pre_n  = 1'b0;
            osc_n  = sc_cnt;
            osym_n = sym_cnt;
            if (sc_cnt == SC_LAST) begin
              sc_n = '0;
              if (sym_cnt == SYM_LAST) begin
                state_n = ST_IDLE;
                sym_n   = '0;
                done_n  = 1'b1;
              end else begin
                sym_n = sym_cnt + SYM_W'(1);
              end
            end else begin
              sc_n = sc_cnt + SC_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= ST_IDLE;
      sc_cnt          <= '0;
      sym_cnt         <= '0;
      o_eq_valid      <= 1'b0;
      o_eq_sync_frame <= 1'b0;
      o_err_resync    <= 1'b0;
      o_frame_done    <= 1'b0;
      o_is_preamble   <= 1'b0;
      o_sc_idx        <= '0;
      o_sym_idx       <= '0;
      o_eq_data_i     <= '0;
      o_eq_data_q     <= '0;
    end else begin
      state           <= state_n;
      sc_cnt          <= sc_n;
      sym_cnt         <= sym_n;
      o_eq_valid      <= fwd;
      o_eq_sync_frame <= sync_n;
      o_err_resync    <= err_n;
      o_frame_done    <= done_n;
      o_is_preamble   <= pre_n;
      o_sc_idx        <= osc_n;
      o_sym_idx       <= osym_n;
      if (fwd) begin
        o_eq_data_i <= i_data_i;
        o_eq_data_q <= i_data_q;
      end
    end
  end

endmodule
